// File: rtl/hamming_unpack.sv
// SECDED Hamming decoder: stage 1 computes syndrome and overall parity, stage 2 corrects/extracts data.
// Latency 2 cycles, one word per cycle; in_ready falls only when both stages are full and out_ready=0.
package hamming_unpack_pkg;
    // Smallest A with 2^A - A - 1 >= dw.
    function automatic int hamming_address_width(input int dw);
        int a;
        a = 1;
        while (((1 << a) - a - 1) < dw) a++;
        return a;
    endfunction
endpackage

module hamming_unpack
    import hamming_unpack_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = hamming_address_width(DATA_WIDTH),
    parameter int CODE_BITS   = ADDR_WIDTH + 1,
    parameter int CODE_WIDTH  = DATA_WIDTH + CODE_BITS,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_WIDTH-1:0]  in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_corrected,
    output logic                   out_uncorrectable,
    output logic [ADDR_WIDTH-1:0]  out_syndrome,
    input  logic                   cnt_clear,
    output logic [COUNT_WIDTH-1:0] cnt_corrected,
    output logic [COUNT_WIDTH-1:0] cnt_uncorrectable
);

    function automatic logic [ADDR_WIDTH-1:0] calc_syndrome(input logic [CODE_WIDTH-1:0] c);
        logic [ADDR_WIDTH-1:0] s;
        s = '0;
        for (int p = 1; p < CODE_WIDTH; p++) begin
            if (c[p]) s = s ^ ADDR_WIDTH'(p);
        end
        return s;
    endfunction

    // Data bits fill the non-power-of-two positions from 3 upward, in order.
    function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [CODE_WIDTH-1:0] c);
        logic [DATA_WIDTH-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 3; p < CODE_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (k < DATA_WIDTH) d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    logic                   r_s1_vld;
    logic [CODE_WIDTH-1:0]  r_s1_code;
    logic [ADDR_WIDTH-1:0]  r_s1_syn;
    logic                   r_s1_par;

    logic                   r_out_vld;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_corr;
    logic                   r_out_unc;
    logic [ADDR_WIDTH-1:0]  r_out_syn;

    logic [COUNT_WIDTH-1:0] r_cnt_corr;
    logic [COUNT_WIDTH-1:0] r_cnt_unc;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_out_hs;
    logic                   w_in_range;
    logic                   w_corr;
    logic                   w_unc;
    logic [CODE_WIDTH-1:0]  w_fixed;
    logic [DATA_WIDTH-1:0]  w_data;

    assign w_s2_adv = !r_out_vld || out_ready;
    assign w_s1_adv = !r_s1_vld || w_s2_adv;
    assign w_out_hs = r_out_vld && out_ready;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_code <= '0;
            r_s1_syn  <= '0;
            r_s1_par  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= calc_syndrome(in_code);
                r_s1_par  <= ^in_code;
            end
        end
    end

    // Odd parity with an out-of-range syndrome means 3+ flips aliased; never flip there.
    always_comb begin
        w_in_range = (int'(r_s1_syn) < CODE_WIDTH);
        w_corr     = r_s1_par && w_in_range;
        w_unc      = (!r_s1_par && (r_s1_syn != '0)) || (r_s1_par && !w_in_range);
        w_fixed    = r_s1_code ^ ({{(CODE_WIDTH-1){1'b0}}, w_corr} << r_s1_syn);
        w_data     = extract_data(w_fixed);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_corr <= 1'b0;
            r_out_unc  <= 1'b0;
            r_out_syn  <= '0;
        end else if (w_s2_adv) begin
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_data <= w_data;
                r_out_corr <= w_corr;
                r_out_unc  <= w_unc;
                r_out_syn  <= r_s1_syn;
            end
        end
    end

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (cnt_clear) begin
            r_cnt_corr <= '0;
            r_cnt_unc  <= '0;
        end else if (w_out_hs) begin
            if (r_out_corr && (r_cnt_corr != '1)) r_cnt_corr <= r_cnt_corr + COUNT_WIDTH'(1);
            if (r_out_unc && (r_cnt_unc != '1))   r_cnt_unc  <= r_cnt_unc + COUNT_WIDTH'(1);
        end
    end

    assign out_valid         = r_out_vld;
    assign out_data          = r_out_data;
    assign out_corrected     = r_out_corr;
    assign out_uncorrectable = r_out_unc;
    assign out_syndrome      = r_out_syn;
    assign cnt_corrected     = r_cnt_corr;
    assign cnt_uncorrectable = r_cnt_unc;

endmodule

// File: tb/tb_hamming_unpack.sv
// Randomized bench for hamming_unpack against an encode/flip reference model and a scoreboard queue.
module tb_hamming_unpack;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int CW = 39;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] in_code = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_corrected;
    logic          out_uncorrectable;
    logic [AW-1:0] out_syndrome;
    logic [NW-1:0] cnt_corrected;
    logic [NW-1:0] cnt_uncorrectable;

    hamming_unpack #(.DATA_WIDTH(DW), .COUNT_WIDTH(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
        .out_syndrome(out_syndrome), .cnt_clear(cnt_clear),
        .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          corr;
        logic          unc;
        logic [AW-1:0] syn;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t          q[$];
    exp_t          drv_exp;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            dpos[DW];
    logic [NW-1:0] m_corr = '0;
    logic [NW-1:0] m_unc = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] d, input logic c, input logic u, input logic [AW-1:0] s);
        exp_t e;
        e.data = d; e.corr = c; e.unc = u; e.syn = s; e.acc = 0; e.lat = 0;
        return e;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int s;
        c = '0;
        s = 0;
        for (int k = 0; k < DW; k++) begin
            if (d[k]) begin
                c[dpos[k]] = 1'b1;
                s = s ^ dpos[k];
            end
        end
        for (int i = 0; i < AW; i++) begin
            if (((s >> i) & 1) != 0) c[1 << i] = 1'b1;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        for (int k = 0; k < DW; k++) d[k] = c[dpos[k]];
        return d;
    endfunction

    // Clean codeword plus 0..2 random flips; expectations follow from flip count and positions.
    task automatic gen(output logic [CW-1:0] c, output exp_t e);
        logic [DW-1:0] d;
        int nf, a, b;
        d  = $urandom;
        nf = $urandom_range(2);
        a  = $urandom_range(CW - 1);
        do b = $urandom_range(CW - 1); while (b == a);
        c = encode(d);
        if (nf == 0) begin
            e = mk(d, 1'b0, 1'b0, '0);
        end else if (nf == 1) begin
            c[a] = ~c[a];
            e = mk(d, 1'b1, 1'b0, AW'(a));
        end else begin
            c[a] = ~c[a];
            c[b] = ~c[b];
            e = mk(extract(c), 1'b0, 1'b1, AW'(a ^ b));
        end
    endtask

    task automatic send(input logic [CW-1:0] c, input exp_t e);
        int g;
        g = 0;
        in_code  = c;
        drv_exp  = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            if (g > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_code  = CW'({$urandom, $urandom});
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 || in_valid) begin
            @(negedge clk);
            g++;
            if (g > 300) begin
                chk("drain_timeout", 64'(q.size()), 64'd0);
                break;
            end
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic set_mode(input int m);
        rdy_mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 3) == 0);
            2:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin : mon
        exp_t e;
        bit   hc, hu;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                m_corr = '0;
                m_unc  = '0;
            end else begin
                hc = 0;
                hu = 0;
                chk("cnt_corrected", 64'(cnt_corrected), 64'(m_corr));
                chk("cnt_uncorrectable", 64'(cnt_uncorrectable), 64'(m_unc));
                chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready && q.size() >= 2)));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 64'd1, 64'd0);
                    end else begin
                        chk("out_data", 64'(out_data), 64'(q[0].data));
                        chk("out_corrected", 64'(out_corrected), 64'(q[0].corr));
                        chk("out_uncorrectable", 64'(out_uncorrectable), 64'(q[0].unc));
                        chk("out_syndrome", 64'(out_syndrome), 64'(q[0].syn));
                        if (out_ready) begin
                            if (q[0].lat) chk("latency", 64'(cyc - q[0].acc), 64'd2);
                            hc = q[0].corr;
                            hu = q[0].unc;
                            void'(q.pop_front());
                        end
                    end
                end
                if (cnt_clear) begin
                    m_corr = '0;
                    m_unc  = '0;
                end else begin
                    if (hc && m_corr != '1) m_corr = m_corr + 1'b1;
                    if (hu && m_unc != '1)  m_unc  = m_unc + 1'b1;
                end
                if (in_valid && in_ready) begin
                    e     = drv_exp;
                    e.acc = cyc;
                    e.lat = (rdy_mode == 0);
                    q.push_back(e);
                end
            end
        end
    end

    initial begin : main
        logic [CW-1:0] c;
        exp_t          e;
        int            k;
        k = 0;
        for (int p = 3; p < CW; p++) begin
            bit pw;
            pw = 0;
            for (int i = 0; i < AW; i++) if (p == (1 << i)) pw = 1;
            if (!pw) begin
                dpos[k] = p;
                k++;
            end
        end

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_corrected", 64'(out_corrected), 64'd0);
        chk("rst_out_uncorrectable", 64'(out_uncorrectable), 64'd0);
        chk("rst_out_syndrome", 64'(out_syndrome), 64'd0);
        chk("rst_cnt_corrected", 64'(cnt_corrected), 64'd0);
        chk("rst_cnt_uncorrectable", 64'(cnt_uncorrectable), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed words from the known layout.
        send(39'h0,           mk(32'h0, 1'b0, 1'b0, 6'd0));
        send(39'hF,           mk(32'h1, 1'b0, 1'b0, 6'd0));
        send(39'h2F,          mk(32'h1, 1'b1, 1'b0, 6'd5));
        send(39'hE,           mk(32'h1, 1'b1, 1'b0, 6'd0));
        send(39'h28,          mk(32'h3, 1'b0, 1'b1, 6'd6));
        send(39'h01_0001_0100, mk(32'h0, 1'b0, 1'b1, 6'd56));
        drain();
        chk("dir_cnt_corrected", 64'(cnt_corrected), 64'd2);
        chk("dir_cnt_uncorrectable", 64'(cnt_uncorrectable), 64'd2);

        set_mode(1);
        for (int i = 0; i < 5; i++) begin
            gen(c, e);
            send(c, e);
        end
        drain();

        set_mode(0);
        for (int i = 0; i < 20; i++) begin
            c = encode(32'(i * 7919));
            k = $urandom_range(CW - 1);
            c[k] = ~c[k];
            send(c, mk(32'(i * 7919), 1'b1, 1'b0, AW'(k)));
        end
        drain();
        chk("sat_cnt_corrected", 64'(cnt_corrected), 64'hF);

        c = encode(32'hDEAD_BEEF);
        c[9] = ~c[9];
        send(c, mk(32'hDEAD_BEEF, 1'b1, 1'b0, 6'd9));
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        chk("clear_cnt_corrected", 64'(cnt_corrected), 64'd0);
        chk("clear_cnt_uncorrectable", 64'(cnt_uncorrectable), 64'd0);
        drain();

        set_mode(2);
        for (int i = 0; i < 300; i++) begin
            gen(c, e);
            send(c, e);
        end
        drain();

        set_mode(3);
        for (int i = 0; i < 2; i++) begin
            gen(c, e);
            send(c, e);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_cnt_corrected", 64'(cnt_corrected), 64'd0);
        chk("midrst_cnt_uncorrectable", 64'(cnt_uncorrectable), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_mode = 0;
        repeat (10) @(negedge clk);
        chk("post_rst_queue", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
